// File: rtl/load_store_unit.sv
// Load/store sequencer between the register file and a single-port data memory.
// Loads wait a fixed memory latency under stall; stores are a one-cycle write.
module load_store_unit #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic          st_req,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    st_data,
    input  logic [3:0]    ld_tag_in,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    loadData,
    output logic          loadEn,
    output logic [3:0]    ld_tag,
    output logic          stall,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state_reg;
    logic [3:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            loadData  <= 8'd0;
            loadEn    <= 1'b0;
            ld_tag    <= 4'd0;
            stall     <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Strobes default low; each is raised for exactly one cycle below.
            mem_we <= 1'b0;
            loadEn <= 1'b0;
            err    <= 1'b0;
            case (state_reg)
                IDLE, RD_DONE: begin
                    state_reg <= IDLE;
                    if (ld_req && st_req) begin
                        err <= 1'b1;
                    end else if (ld_req) begin
                        mem_addr  <= addr;
                        ld_tag    <= ld_tag_in;
                        cnt_reg   <= CNT_INIT;
                        mem_re    <= 1'b1;
                        stall     <= 1'b1;
                        state_reg <= RD_WAIT;
                    end else if (st_req) begin
                        mem_addr  <= addr;
                        mem_wdata <= st_data;
                        mem_we    <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    // Requests arriving mid-load are dropped, the load carries on.
                    if (ld_req || st_req) begin
                        err <= 1'b1;
                    end
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        loadData  <= mem_rdata;
                        loadEn    <= 1'b1;
                        mem_re    <= 1'b0;
                        stall     <= 1'b0;
                        state_reg <= RD_DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
